// File: rtl/jtag_tap_gate.sv
// jtag_tap_gate
// Lock-aware IEEE 1149.1 TAP controller driving an on-chip debug bus.
// The TAP advances only on clk edges qualified by tck_en (a TCK rising
// edge strobe). Instructions: 4'hF BYPASS, 4'h1 IDCODE, 4'h8 DBG (40-bit
// debug-access DR). While lock_jtag is high, DBG behaves as BYPASS, no debug
// strobe is issued, and lock_viol latches until reset.
//
// Ports:
//   clk        system clock, all state changes on its rising edge
//   reset      asynchronous active-high reset
//   tck_en     one-clk strobe marking a TCK rising edge
//   tms, tdi   TAP inputs, sampled when tck_en=1
//   lock_jtag  1 = debug access forbidden
//   dbg_rdata  debug read data, sampled when leaving Capture-DR
//   tdo        test data out (0 outside Shift-IR/Shift-DR)
//   tdo_oe     high only in Shift-IR/Shift-DR
//   dbg_addr   debug address, dbg_wdata debug write data
//   dbg_wr     one-clk write strobe, dbg_rd one-clk read strobe
//   lock_viol  sticky flag: DBG access attempted while locked
module jtag_tap_gate #(
    parameter logic [31:0] IDCODE = 32'h1000_0001,
    parameter int unsigned IR_W   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tck_en,
    input  logic        tms,
    input  logic        tdi,
    input  logic        lock_jtag,
    input  logic [31:0] dbg_rdata,
    output logic        tdo,
    output logic        tdo_oe,
    output logic [6:0]  dbg_addr,
    output logic [31:0] dbg_wdata,
    output logic        dbg_wr,
    output logic        dbg_rd,
    output logic        lock_viol
);

    localparam logic [IR_W-1:0] IR_IDCODE  = IR_W'(4'h1);
    localparam logic [IR_W-1:0] IR_DBG     = IR_W'(4'h8);
    localparam logic [IR_W-1:0] IR_CAPTURE = IR_W'(4'b0101);

    typedef enum logic [3:0] {
        TLR    = 4'h0, RTI    = 4'h1,
        SEL_DR = 4'h2, CAP_DR = 4'h3, SH_DR  = 4'h4, EX1_DR = 4'h5,
        PAU_DR = 4'h6, EX2_DR = 4'h7, UPD_DR = 4'h8,
        SEL_IR = 4'h9, CAP_IR = 4'hA, SH_IR  = 4'hB, EX1_IR = 4'hC,
        PAU_IR = 4'hD, EX2_IR = 4'hE, UPD_IR = 4'hF
    } tap_state_e;

    tap_state_e       state_q, state_d, tap_next_s;
    logic [IR_W-1:0]  ir_q, ir_d, ir_sr_q, ir_sr_d;
    logic             byp_q, byp_d;
    logic [31:0]      id_sr_q, id_sr_d;
    logic [39:0]      dbg_sr_q, dbg_sr_d;
    logic [6:0]       addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic             wr_q, wr_d, rd_q, rd_d;
    logic             viol_q, viol_d;
    logic             tdo_q, tdo_d, oe_q, oe_d;

    logic             dbg_sel_s, dbg_eff_s, id_eff_s;

    // The DBG register is only reachable while unlocked; locked DBG falls back to bypass.
    assign dbg_sel_s = (ir_q == IR_DBG);
    assign dbg_eff_s = dbg_sel_s & ~lock_jtag;
    assign id_eff_s  = (ir_q == IR_IDCODE);

    // TAP state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= TLR;
        end else begin
            state_q <= state_d;
        end
    end

    // Standard 1149.1 TMS transitions, taken only on a TCK strobe
    always_comb begin
        tap_next_s = state_q;
        case (state_q)
            TLR:     tap_next_s = tms ? TLR    : RTI;
            RTI:     tap_next_s = tms ? SEL_DR : RTI;
            SEL_DR:  tap_next_s = tms ? SEL_IR : CAP_DR;
            CAP_DR:  tap_next_s = tms ? EX1_DR : SH_DR;
            SH_DR:   tap_next_s = tms ? EX1_DR : SH_DR;
            EX1_DR:  tap_next_s = tms ? UPD_DR : PAU_DR;
            PAU_DR:  tap_next_s = tms ? EX2_DR : PAU_DR;
            EX2_DR:  tap_next_s = tms ? UPD_DR : SH_DR;
            UPD_DR:  tap_next_s = tms ? SEL_DR : RTI;
            SEL_IR:  tap_next_s = tms ? TLR    : CAP_IR;
            CAP_IR:  tap_next_s = tms ? EX1_IR : SH_IR;
            SH_IR:   tap_next_s = tms ? EX1_IR : SH_IR;
            EX1_IR:  tap_next_s = tms ? UPD_IR : PAU_IR;
            PAU_IR:  tap_next_s = tms ? EX2_IR : PAU_IR;
            EX2_IR:  tap_next_s = tms ? UPD_IR : SH_IR;
            UPD_IR:  tap_next_s = tms ? SEL_DR : RTI;
            default: tap_next_s = TLR;
        endcase
        if (tck_en) begin
            state_d = tap_next_s;
        end else begin
            state_d = state_q;
        end
    end

    // Capture/shift/update actions and registered TAP/debug outputs
    always_comb begin
        ir_d     = ir_q;
        ir_sr_d  = ir_sr_q;
        byp_d    = byp_q;
        id_sr_d  = id_sr_q;
        dbg_sr_d = dbg_sr_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        wr_d     = 1'b0;   // debug strobes self-clear every clk
        rd_d     = 1'b0;
        viol_d   = viol_q;
        tdo_d    = tdo_q;  // tdo/tdo_oe hold between strobes
        oe_d     = oe_q;
        if (tck_en) begin
            // Capture and shift act in the state being left on this strobe
            case (state_q)
                CAP_IR: ir_sr_d = IR_CAPTURE;
                SH_IR:  ir_sr_d = {tdi, ir_sr_q[IR_W-1:1]};
                CAP_DR: begin
                    if (dbg_eff_s) begin
                        dbg_sr_d = {dbg_rdata, addr_q, 1'b0};
                    end else if (id_eff_s) begin
                        id_sr_d = IDCODE;
                    end else begin
                        byp_d = 1'b0;
                    end
                end
                SH_DR: begin
                    if (dbg_eff_s) begin
                        dbg_sr_d = {tdi, dbg_sr_q[39:1]};
                    end else if (id_eff_s) begin
                        id_sr_d = {tdi, id_sr_q[31:1]};
                    end else begin
                        byp_d = tdi;
                    end
                end
                default: ;
            endcase

            // Any DR capture/shift/update attempt under a locked DBG is flagged
            if (dbg_sel_s && lock_jtag &&
                ((state_q == CAP_DR) || (state_q == SH_DR) || (tap_next_s == UPD_DR))) begin
                viol_d = 1'b1;
            end else begin
                viol_d = viol_q;
            end

            // Debug access fires on the edge entering Update-DR
            if ((tap_next_s == UPD_DR) && dbg_eff_s) begin
                addr_d  = dbg_sr_q[7:1];
                wdata_d = dbg_sr_q[39:8];
                wr_d    = dbg_sr_q[0];
                rd_d    = ~dbg_sr_q[0];
            end else begin
                addr_d  = addr_q;
                wdata_d = wdata_q;
            end

            if (tap_next_s == UPD_IR) begin
                ir_d = ir_sr_q;
            end else if (tap_next_s == TLR) begin
                ir_d = IR_IDCODE;
            end else begin
                ir_d = ir_q;
            end

            // tdo shows the LSB of the register as it stands after this edge
            if (tap_next_s == SH_IR) begin
                oe_d  = 1'b1;
                tdo_d = ir_sr_d[0];
            end else if (tap_next_s == SH_DR) begin
                oe_d  = 1'b1;
                tdo_d = dbg_eff_s ? dbg_sr_d[0] : (id_eff_s ? id_sr_d[0] : byp_d);
            end else begin
                oe_d  = 1'b0;
                tdo_d = 1'b0;
            end
        end else begin
            viol_d = viol_q;
        end
    end

    // Instruction, shift and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ir_q     <= IR_IDCODE;
            ir_sr_q  <= '0;
            byp_q    <= 1'b0;
            id_sr_q  <= 32'h0;
            dbg_sr_q <= 40'h0;
            addr_q   <= 7'h0;
            wdata_q  <= 32'h0;
            wr_q     <= 1'b0;
            rd_q     <= 1'b0;
            viol_q   <= 1'b0;
            tdo_q    <= 1'b0;
            oe_q     <= 1'b0;
        end else begin
            ir_q     <= ir_d;
            ir_sr_q  <= ir_sr_d;
            byp_q    <= byp_d;
            id_sr_q  <= id_sr_d;
            dbg_sr_q <= dbg_sr_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            wr_q     <= wr_d;
            rd_q     <= rd_d;
            viol_q   <= viol_d;
            tdo_q    <= tdo_d;
            oe_q     <= oe_d;
        end
    end

    assign tdo       = tdo_q;
    assign tdo_oe    = oe_q;
    assign dbg_addr  = addr_q;
    assign dbg_wdata = wdata_q;
    assign dbg_wr    = wr_q;
    assign dbg_rd    = rd_q;
    assign lock_viol = viol_q;

endmodule

// File: tb/tb_jtag_tap_gate.sv
// Testbench for jtag_tap_gate: directed vector table, hand-written corner
// sequences (TMS reset from Pause-DR, reset mid-shift) and randomized scans
// compared against a bit-stream reference model of the TAP registers.
module tb_jtag_tap_gate;

    localparam logic [31:0] IDC = 32'h1000_0001;

    logic        clk = 1'b0;
    logic        reset, tck_en, tms, tdi, lock_jtag;
    logic [31:0] dbg_rdata;
    logic        tdo, tdo_oe, dbg_wr, dbg_rd, lock_viol;
    logic [6:0]  dbg_addr;
    logic [31:0] dbg_wdata;

    int n_checks = 0;
    int n_fail   = 0;
    int wr_cnt   = 0;
    int rd_cnt   = 0;

    // reference model state
    logic [3:0]  m_ir;
    logic        m_viol;
    logic [6:0]  m_addr;
    logic [31:0] m_wdata;

    typedef struct {
        logic [3:0]  ir;
        logic        lock;
        int          n;
        logic [63:0] tv;
        logic [31:0] rdata;
        logic [63:0] e_tdo;
        int          e_wr;
        int          e_rd;
        logic [6:0]  e_addr;
        logic [31:0] e_wdata;
        logic        e_viol;
    } vec_t;

    vec_t vt [5];

    jtag_tap_gate #(.IDCODE(IDC), .IR_W(4)) dut (
        .clk(clk), .reset(reset), .tck_en(tck_en), .tms(tms), .tdi(tdi),
        .lock_jtag(lock_jtag), .dbg_rdata(dbg_rdata), .tdo(tdo), .tdo_oe(tdo_oe),
        .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata), .dbg_wr(dbg_wr),
        .dbg_rd(dbg_rd), .lock_viol(lock_viol)
    );

    always #5 clk = ~clk;

    // count high cycles of each debug strobe
    always @(negedge clk) begin
        if (dbg_wr) wr_cnt++;
        if (dbg_rd) rd_cnt++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    function automatic logic rb();
        rb = 1'($urandom);
    endfunction

    function automatic logic [63:0] msk(input int n);
        msk = (64'd1 << n) - 64'd1;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic strobe(input logic t_ms, input logic t_di);
        @(negedge clk);
        tck_en = 1'b1;
        tms    = t_ms;
        tdi    = t_di;
        @(negedge clk);
        tck_en = 1'b0;
    endtask

    task automatic model_reset();
        m_ir    = 4'h1;
        m_viol  = 1'b0;
        m_addr  = 7'h0;
        m_wdata = 32'h0;
    endtask

    // DR scan as a stream: captured bits come out first, then the tdi bits;
    // the register keeps the last L bits of that stream.
    task automatic model_dr(input int n, input logic [63:0] tv,
                            output logic [63:0] e_tdo, output int e_wr, output int e_rd);
        int           len;
        logic [127:0] cap, stream;
        logic [39:0]  fin;
        if (m_ir == 4'h1) begin
            len = 32; cap = {96'd0, IDC};
        end else if (m_ir == 4'h8 && !lock_jtag) begin
            len = 40; cap = {88'd0, dbg_rdata, m_addr, 1'b0};
        end else begin
            len = 1; cap = 128'd0;
        end
        stream = cap | ({64'd0, tv & msk(n)} << len);
        e_tdo  = stream[63:0] & msk(n);
        fin    = stream[n +: 40];
        e_wr   = 0;
        e_rd   = 0;
        if (m_ir == 4'h8) begin
            if (lock_jtag) begin
                m_viol = 1'b1;
            end else begin
                m_addr  = fin[7:1];
                m_wdata = fin[39:8];
                if (fin[0]) e_wr = 1; else e_rd = 1;
            end
        end
    endtask

    // From RTI: load a 4-bit instruction, back to RTI
    task automatic ir_scan(input logic [3:0] v);
        logic [3:0] got;
        strobe(1'b1, rb());
        strobe(1'b1, rb());
        strobe(1'b0, rb());
        strobe(1'b0, rb());
        got[0] = tdo;
        for (int k = 0; k < 4; k++) begin
            strobe(k == 3, v[k]);
            if (k < 3) got[k+1] = tdo;
        end
        strobe(1'b1, rb());
        strobe(1'b0, rb());
        check("ir_capture_pattern", 64'(got), 64'h5);
        m_ir = v;
    endtask

    // From RTI: n-bit DR scan, optional Pause-DR detour after shift index pa
    task automatic do_dr(input int n, input logic [63:0] tv, input int pa,
                         output logic [63:0] got, output int dwr, output int drd);
        int   wr0, rd0;
        logic last, oe_all;
        wr0 = wr_cnt;
        rd0 = rd_cnt;
        got = 64'd0;
        strobe(1'b1, rb());
        strobe(1'b0, rb());
        strobe(1'b0, rb());
        got[0] = tdo;
        oe_all = tdo_oe;
        for (int k = 0; k < n; k++) begin
            last = (k == n - 1);
            strobe(last || (k == pa), tv[k]);
            if (!last && k == pa) begin
                check("dr_oe_exit1", 64'(tdo_oe), 64'd0);
                strobe(1'b0, rb());
                strobe(1'b1, rb());
                strobe(1'b0, rb());
            end
            if (!last) begin
                got[k+1] = tdo;
                oe_all   = oe_all & tdo_oe;
            end
        end
        check("dr_oe_during_shift", 64'(oe_all), 64'd1);
        check("dr_oe_tdo_after_shift", 64'({tdo_oe, tdo}), 64'd0);
        strobe(1'b1, rb());
        strobe(1'b0, rb());
        dwr = wr_cnt - wr0;
        drd = rd_cnt - rd0;
    endtask

    task automatic compare_dr(input int n, input logic [63:0] tv, input int pa,
                              input logic [63:0] e_tdo, input int e_wr, input int e_rd,
                              input logic [6:0] e_addr, input logic [31:0] e_wdata,
                              input logic e_viol);
        logic [63:0] got;
        int          dwr, drd;
        do_dr(n, tv, pa, got, dwr, drd);
        check("dr_tdo_stream", got & msk(n), e_tdo);
        check("dbg_wr_cycles", 64'(dwr), 64'(e_wr));
        check("dbg_rd_cycles", 64'(drd), 64'(e_rd));
        check("dbg_addr", 64'(dbg_addr), 64'(e_addr));
        check("dbg_wdata", 64'(dbg_wdata), 64'(e_wdata));
        check("lock_viol", 64'(lock_viol), 64'(e_viol));
    endtask

    task automatic check_reset_values();
        check("rst_tdo", 64'(tdo), 64'd0);
        check("rst_tdo_oe", 64'(tdo_oe), 64'd0);
        check("rst_dbg_addr", 64'(dbg_addr), 64'd0);
        check("rst_dbg_wdata", 64'(dbg_wdata), 64'd0);
        check("rst_dbg_wr", 64'(dbg_wr), 64'd0);
        check("rst_dbg_rd", 64'(dbg_rd), 64'd0);
        check("rst_lock_viol", 64'(lock_viol), 64'd0);
    endtask

    initial begin
        logic [3:0]  code;
        logic [63:0] tv, e_tdo;
        int          n, pa, e_wr, e_rd, wr0, rd0;

        vt[0] = '{4'h1, 1'b0, 32, 64'h0, 32'h0, 64'h1000_0001, 0, 0, 7'h00, 32'h0, 1'b0};
        vt[1] = '{4'h8, 1'b0, 40, 64'h12_3456_7815, 32'h0, 64'h0, 1, 0, 7'h0A, 32'h1234_5678, 1'b0};
        vt[2] = '{4'h8, 1'b0, 40, 64'h06, 32'h0, 64'h14, 0, 1, 7'h03, 32'h0, 1'b0};
        vt[3] = '{4'h8, 1'b0, 40, 64'h06, 32'hDEAD_BEEF, 64'hDE_ADBE_EF06, 0, 1, 7'h03, 32'h0, 1'b0};
        vt[4] = '{4'h8, 1'b1, 40, 64'hF1, 32'h0, 64'h1E2, 0, 0, 7'h03, 32'h0, 1'b1};

        reset = 1'b1; tck_en = 1'b0; tms = 1'b0; tdi = 1'b0;
        lock_jtag = 1'b0; dbg_rdata = 32'h0;
        repeat (3) @(negedge clk);
        check_reset_values();
        reset = 1'b0;
        model_reset();
        strobe(1'b0, 1'b0);

        // directed vector table
        for (int r = 0; r < 5; r++) begin
            lock_jtag = vt[r].lock;
            dbg_rdata = vt[r].rdata;
            ir_scan(vt[r].ir);
            model_dr(vt[r].n, vt[r].tv, e_tdo, e_wr, e_rd);
            compare_dr(vt[r].n, vt[r].tv, -1, vt[r].e_tdo, vt[r].e_wr, vt[r].e_rd,
                       vt[r].e_addr, vt[r].e_wdata, vt[r].e_viol);
        end

        // TMS reset from Pause-DR while locked DBG is active
        ir_scan(4'h8);
        wr0 = wr_cnt;
        rd0 = rd_cnt;
        strobe(1'b1, rb());
        strobe(1'b0, rb());
        strobe(1'b0, rb());
        strobe(1'b0, 1'b1);
        strobe(1'b1, 1'b0);
        strobe(1'b0, rb());
        check("pause_tdo_oe", 64'(tdo_oe), 64'd0);
        repeat (5) strobe(1'b1, rb());
        check("tlr_no_wr", 64'(wr_cnt - wr0), 64'd0);
        check("tlr_no_rd", 64'(rd_cnt - rd0), 64'd0);
        check("tlr_viol_sticky", 64'(lock_viol), 64'd1);
        strobe(1'b0, rb());
        m_ir = 4'h1;
        lock_jtag = 1'b0;
        tv = {$urandom, $urandom};
        model_dr(32, tv, e_tdo, e_wr, e_rd);
        check("tlr_ir_is_idcode", e_tdo, 64'(IDC));
        compare_dr(32, tv, -1, e_tdo, e_wr, e_rd, m_addr, m_wdata, m_viol);

        // reset clears the sticky violation
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_reset_values();
        reset = 1'b0;
        model_reset();
        strobe(1'b0, rb());

        // reset in the middle of a DBG shift, coinciding with a strobe
        ir_scan(4'h8);
        wr0 = wr_cnt;
        rd0 = rd_cnt;
        strobe(1'b1, rb());
        strobe(1'b0, rb());
        strobe(1'b0, rb());
        check("shift_oe_before_reset", 64'(tdo_oe), 64'd1);
        @(negedge clk);
        tck_en = 1'b1; tms = 1'b1; tdi = 1'b1; reset = 1'b1;
        @(negedge clk);
        tck_en = 1'b0;
        check("midshift_reset_oe", 64'({tdo_oe, tdo}), 64'd0);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("midshift_reset_no_strobe", 64'((wr_cnt - wr0) + (rd_cnt - rd0)), 64'd0);
        model_reset();
        strobe(1'b0, rb());

        // randomized scans against the model
        for (int i = 0; i < 60; i++) begin
            lock_jtag = ($urandom_range(0, 7) == 0);
            dbg_rdata = $urandom;
            if ($urandom_range(0, 3) == 0) begin
                case ($urandom_range(0, 3))
                    0:       code = 4'h1;
                    1:       code = 4'h8;
                    2:       code = 4'hF;
                    default: code = 4'($urandom);
                endcase
                ir_scan(code);
            end else begin
                if (m_ir == 4'h8 && $urandom_range(0, 1) == 1) n = 40;
                else n = int'($urandom_range(1, 45));
                tv = {$urandom, $urandom};
                if ($urandom_range(0, 2) == 0) pa = int'($urandom_range(0, n - 1));
                else pa = -1;
                model_dr(n, tv, e_tdo, e_wr, e_rd);
                compare_dr(n, tv, pa, e_tdo, e_wr, e_rd, m_addr, m_wdata, m_viol);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/jtag_tap_gate.md
# jtag_tap_gate

Lock-aware JTAG TAP controller on the debug side of the JTAG lock register. It runs the IEEE 1149.1 16-state TAP FSM from a synchronous TCK strobe and provides three instructions: BYPASS, IDCODE and a 40-bit debug-access DR. The DR drives the on-chip debug bus. While `lock_jtag` is high, all debug-bus access is suppressed and every blocked attempt is flagged.

## Interface
Parameters:
- `IDCODE`, 32'h1000_0001, value returned by IDCODE (bit 0 must be 1)
- `IR_W`, 4, instruction register width

Ports:
- `clk`  in  1  system clock; all state changes occur on its rising edge
- `reset`  in  1  asynchronous, active-high reset
- `tck_en`  in  1  one-`clk` strobe marking a TCK rising edge (synchronised upstream)
- `tms`  in  1  test mode select, sampled when `tck_en`=1
- `tdi`  in  1  test data in, sampled when `tck_en`=1
- `lock_jtag`  in  1  debug lock from the lock register; 1 = debug access forbidden
- `dbg_rdata`  in  32  debug-bus read data, sampled at Capture-DR
- `tdo`  out  1  test data out
- `tdo_oe`  out  1  high only in Shift-IR / Shift-DR
- `dbg_addr`  out  7  debug-bus address
- `dbg_wdata`  out  32  debug-bus write data
- `dbg_wr`  out  1  one-`clk` write strobe
- `dbg_rd`  out  1  one-`clk` read strobe
- `lock_viol`  out  1  sticky: a DBG access was attempted while locked

## Operation
- **TAP FSM.** Standard 16 states (TLR, RTI, Select/Capture/Shift/Exit1/Pause/Exit2/Update for DR and IR) with standard TMS transitions. Advances only on `clk` edges where `tck_en`=1. Five consecutive TMS=1 strobes reach TLR from any state.
- **Instructions.** 4'hF BYPASS (1-bit DR, captures 0); 4'h1 IDCODE (32-bit DR); 4'h8 DBG (40-bit DR). Every other code behaves as BYPASS.
- **Instruction register.**
  - In TLR, IR is set to IDCODE.
  - Capture-IR loads 4'b0101.
  - Shift-IR shifts `tdi` into the MSB; the LSB drives `tdo`.
  - Update-IR copies the shift value to the active IR.
- **Effective instruction.** If the active IR is DBG while `lock_jtag`=1, it behaves as BYPASS for capture and shift, and `lock_viol` is set. `lock_jtag` is re-evaluated on every strobe.
- **DBG DR layout.** Bit 0 = wr, bits 7:1 = addr, bits 39:8 = data.
  - Capture-DR loads {`dbg_rdata`, `dbg_addr`, 1'b0}.
  - Shift is LSB first, with `tdi` entering bit 39.
- **Update-DR with DBG effective and `lock_jtag`=0:**
  - `dbg_addr` and `dbg_wdata` are loaded from the DR.
  - `dbg_wr` pulses if wr=1; otherwise `dbg_rd` pulses.
- **Update-DR with DBG active but `lock_jtag`=1:** no strobe; `lock_viol` set.
- **`lock_viol`.** Cleared only by `reset`; TLR does not clear it.
- **IDCODE.** Capture loads the `IDCODE` parameter; shift is LSB first.
- **`tdo`.** Equals the LSB of the selected shift register while `tdo_oe`=1; otherwise 0.

## Timing
- **Reset values.** State=TLR, IR=IDCODE, all shift registers 0. `tdo`=0, `tdo_oe`=0, `dbg_addr`=0, `dbg_wdata`=0, `dbg_wr`=0, `dbg_rd`=0, `lock_viol`=0.
- **Reset mid-operation.** Aborts any shift immediately. No strobe issues for a pending update.
- **`tdo` / `tdo_oe` updates.** Registered, on the same `clk` edge as the strobe that enters or advances within a Shift state. Held stable until the next `tck_en`.
- **Debug strobes.**
  - `dbg_wr` / `dbg_rd` assert on the `clk` edge where the FSM enters Update-DR, and deassert on the next `clk` edge (exactly 1 cycle).
  - `dbg_addr` / `dbg_wdata` change on the same edge and hold until the next update.
- **Capture timing.** Capture-DR samples `dbg_rdata` on the strobe edge that leaves Capture-DR. Read data therefore reflects the previous read, at least one TCK later.
- **Idle behaviour.** With `tck_en`=0, no state, register or output changes, except that `dbg_wr` / `dbg_rd` self-clear.
- **Simultaneous `tck_en` and `reset`.** Reset wins.

## Test plan
- **Reset and IDCODE.** Reset, then TMS=0 into RTI, select DR, shift 32 bits → `tdo` sequence equals `IDCODE` LSB first, starting with 1.
- **Capture-IR pattern.** Shift-IR with `tdi`=1 for 4 bits → first 4 `tdo` bits are 1,0,1,0.
- **DBG write.** IR=8, `lock_jtag`=0, shift DR=40'h12345678_15 (wr=1, addr=0x0A) → single 1-cycle `dbg_wr`, `dbg_addr`=7'h0A, `dbg_wdata`=32'h12345678.
- **DBG read.** Read of addr 3, then `dbg_rdata`=32'hDEADBEEF, then a second DR scan → `dbg_rd` pulses once; bits 39:8 shifted out = 32'hDEADBEEF.
- **Locked access.** `lock_jtag`=1, IR=8, 40-bit scan → no `dbg_wr`/`dbg_rd`, `lock_viol`=1, DR acts as 1-bit bypass (`tdi` appears on `tdo` one strobe later). `lock_viol` stays set after 5×TMS=1, clears only on `reset`.
- **TMS reset.** TMS=1 for 5 strobes from Pause-DR → TLR, IR=IDCODE, no debug strobe.
